leiwand_rv32_uart_tx: RTL

LEIWAND_RV32_UART_TX -- requirements
Module: leiwand_rv32_uart_tx

---
 rtl/leiwand_rv32_uart_tx.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/leiwand_rv32_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a TX FIFO on a valid/ready RV32-style bus.
// Offset 0x0 pushes a byte; offset 0x4 reports FIFO/FSM status and a read-to-clear overrun flag.
module leiwand_rv32_uart_tx #(
    parameter int CLK_DIV    = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int XLEN       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid,
    output logic              ready,
    input  logic [XLEN/8-1:0] wen,
    input  logic [XLEN-1:0]   addr,
    input  logic [XLEN-1:0]   wdata,
    output logic [XLEN-1:0]   rdata,
    output logic              txd
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(CLK_DIV);

    localparam logic [BW-1:0] BAUD_MAX      = BW'(CLK_DIV - 1);
    localparam logic [CW-1:0] FIFO_FULL_LVL = CW'(FIFO_DEPTH);
    localparam logic [15:0]   OFS_TXD       = 16'h0000;
    localparam logic [15:0]   OFS_STATUS    = 16'h0004;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_e;

    // Bus-side state
    logic            ready_q;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            overrun_q, overrun_d;

    // FIFO state
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;

    // Transmitter state
    state_e        state_q;
    logic [7:0]    shift_q;
    logic [2:0]    bit_cnt_q;
    logic [BW-1:0] baud_q;
    logic          txd_q;

    logic            access_exec, is_write, sel_txd, sel_status;
    logic            push_req, push, push_drop, pop, status_rd;
    logic            fifo_full, fifo_empty, tx_busy;
    logic [XLEN-1:0] status_w;
    logic            unused_bits;

    // A request executes only on its first cycle; ready_q masks the held-valid cycles.
    assign access_exec = valid && !ready_q;
    assign is_write    = |wen;
    assign sel_txd     = (addr[15:0] == OFS_TXD);
    assign sel_status  = (addr[15:0] == OFS_STATUS);

    assign fifo_full  = (count_q == FIFO_FULL_LVL);
    assign fifo_empty = (count_q == '0);
    assign tx_busy    = (state_q != IDLE);

    assign push_req  = access_exec && is_write && sel_txd && wen[0];
    assign push      = push_req && !fifo_full;
    assign push_drop = push_req && fifo_full;
    assign pop       = (state_q == IDLE) && !fifo_empty;
    assign status_rd = access_exec && !is_write && sel_status;

    assign unused_bits = ^{addr[XLEN-1:16], wdata[XLEN-1:8]};

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        status_w        = '0;
        status_w[0]     = fifo_full;
        status_w[1]     = fifo_empty;
        status_w[2]     = tx_busy;
        status_w[3]     = overrun_q;
        status_w[15:8]  = 8'(count_q);

        rdata_d = '0;
        if (!is_write && sel_status) begin
            rdata_d = status_w;
        end

        // A drop in the same cycle as the clearing read keeps the flag set.
        overrun_d = overrun_q;
        if (status_rd) begin
            overrun_d = 1'b0;
        end
        if (push_drop) begin
            overrun_d = 1'b1;
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            ready_q   <= 1'b0;
            rdata_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            ready_q   <= valid;
            overrun_q <= overrun_d;
            if (access_exec) begin
                rdata_q <= rdata_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    // NOTE: storage is not reset; the pointers and count alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wdata[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            baud_q    <= '0;
            txd_q     <= 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    txd_q <= 1'b1;
                    if (!fifo_empty) begin
                        shift_q   <= mem_q[rd_ptr_q];
                        bit_cnt_q <= '0;
                        baud_q    <= '0;
                        txd_q     <= 1'b0;
                        state_q   <= START;
                    end
                end
                START: begin
                    if (baud_q == BAUD_MAX) begin
                        baud_q  <= '0;
                        txd_q   <= shift_q[0];
                        state_q <= DATA;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_q == BAUD_MAX) begin
                        baud_q <= '0;
                        if (bit_cnt_q == 3'd7) begin
                            txd_q   <= 1'b1;
                            state_q <= STOP;
                        end else begin
                            // Drive the next bit straight from shift_q[1] so txd stays registered.
                            shift_q   <= shift_q >> 1;
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                            txd_q     <= shift_q[1];
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                STOP: begin
                    if (baud_q == BAUD_MAX) begin
                        baud_q  <= '0;
                        state_q <= IDLE;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ready = ready_q;
    assign rdata = rdata_q;
    assign txd   = txd_q;

endmodule
